// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//
// Sequences HI/LO-class instructions in EX and owns the architectural HI/LO
// register pair. Multiplies go to an external fixed-latency multiplier. Divides
// go to an external iterative divider using a start/ready handshake. MTHI/MTLO
// write HI/LO directly. While a multiply or divide is in flight, the block raises
// stallreq to hold the EX instruction.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   op_valid, op             HI/LO-class op in EX (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                            4 MTHI, 5 MTLO, 6/7 no-op)
//   src_a, src_b             rs / rt operand values
//   ex_advance               EX instruction moves to MEM at the end of this cycle
//   flush                    abort the in-flight operation (highest priority)
//   stallreq                 hold EX (combinational)
//   busy                     sequencer is not idle
//   hi_o, lo_o               architectural HI/LO (registered)
//   mul_signed/ina/inb       multiplier controls, driven only in the multiply state
//   mul_result               {hi, lo} product, valid MUL_LAT cycles after the inputs
//   div_start/signed/opdata* divider controls, driven only in the divide state
//   div_annul                one-cycle divider abort on flush during a divide
//   div_result, div_ready    {remainder, quotient} and its one-cycle valid pulse

module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_advance,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    // Remaining multiply cycles after the issue cycle; reaching 0 marks the
    // cycle in which mul_result is sampled.
    localparam logic [2:0] CntInit = 3'(MUL_LAT - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StWaitAdv} state_e;

    state_e      state_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        sgn_q;
    logic [2:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic is_mul;
    logic is_div;
    logic is_mt;
    logic div_zero;
    logic in_mul;
    logic in_div;

    always_comb begin
        is_mul   = op_valid && (op == OpMult || op == OpMultu);
        is_div   = op_valid && (op == OpDiv || op == OpDivu);
        is_mt    = op_valid && (op == OpMthi || op == OpMtlo);
        div_zero = is_div && (src_b == 32'd0);
        in_mul   = (state_q == StMul);
        in_div   = (state_q == StDiv);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            sgn_q   <= 1'b0;
            cnt_q   <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_mul || (is_div && !div_zero)) begin
                        opa_q   <= src_a;
                        opb_q   <= src_b;
                        sgn_q   <= ~op[0];
                        cnt_q   <= CntInit;
                        state_q <= is_mul ? StMul : StDiv;
                    end else if (is_div || is_mt) begin
                        // Divide by zero is skipped; MTHI/MTLO complete here.
                        if (is_mt) begin
                            if (op == OpMthi) begin
                                hi_q <= src_a;
                            end else begin
                                lo_q <= src_a;
                            end
                        end
                        state_q <= ex_advance ? StIdle : StWaitAdv;
                    end
                end
                StMul: begin
                    if (cnt_q == 3'd0) begin
                        hi_q    <= mul_result[63:32];
                        lo_q    <= mul_result[31:0];
                        state_q <= StWaitAdv;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StDiv: begin
                    if (div_ready) begin
                        hi_q    <= div_result[63:32];
                        lo_q    <= div_result[31:0];
                        state_q <= ex_advance ? StIdle : StWaitAdv;
                    end
                end
                StWaitAdv: begin
                    // op_valid ignored: the instruction already executed and is
                    // only waiting for downstream to let it go.
                    if (ex_advance) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stallreq = 1'b0;
        if (!flush) begin
            unique case (state_q)
                StIdle:    stallreq = is_mul || (is_div && !div_zero);
                StMul:     stallreq = 1'b1;
                StDiv:     stallreq = ~div_ready;
                StWaitAdv: stallreq = 1'b0;
                default:   stallreq = 1'b0;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        hi_o        = hi_q;
        lo_o        = lo_q;
        mul_signed  = in_mul & sgn_q;
        mul_ina     = in_mul ? opa_q : 32'd0;
        mul_inb     = in_mul ? opb_q : 32'd0;
        div_start   = in_div;
        div_signed  = in_div & sgn_q;
        div_opdata1 = in_div ? opa_q : 32'd0;
        div_opdata2 = in_div ? opb_q : 32'd0;
        div_annul   = in_div & flush;
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl. The driver issues ops the way a pipeline
// holds EX on stallreq. It pushes the expected HI/LO and the expected stall and
// div_start cycle counts into a queue. A monitor pops one entry for each
// instruction that leaves EX and checks the DUT.
module tb_hilo_muldiv_ctrl;

    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_advance;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .ex_advance (ex_advance),
        .flush      (flush),
        .stallreq   (stallreq),
        .busy       (busy),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .mul_signed (mul_signed),
        .mul_ina    (mul_ina),
        .mul_inb    (mul_inb),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_opdata1(div_opdata1),
        .div_opdata2(div_opdata2),
        .div_annul  (div_annul),
        .div_result (div_result),
        .div_ready  (div_ready)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint p;
        if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // {remainder, quotient}, truncating toward zero
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint q;
        longint r;
        if (b == 32'd0) return 64'hbad0_bad0_bad0_bad0;
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // ---------------- multiplier model ----------------
    // Output at cycle t is the product of the inputs presented at t-(MUL_LAT-1).
    logic [63:0] mul_prod;
    logic [63:0] mul_pipe [MUL_LAT];
    always_comb mul_prod = ref_mul(mul_ina, mul_inb, mul_signed);
    always @(posedge clk) begin
        mul_pipe[0] <= mul_prod;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    if (MUL_LAT == 1) begin : g_mul_comb
        assign mul_result = mul_prod;
    end else begin : g_mul_pipe
        assign mul_result = mul_pipe[MUL_LAT-2];
    end

    // ---------------- divider model ----------------
    // Ready arrives in the div_lat-th consecutive cycle of div_start.
    int unsigned div_lat = 33;
    int unsigned div_cnt = 0;
    logic        stray_ready = 1'b0;
    always @(posedge clk) div_cnt <= div_start ? div_cnt + 1 : 0;
    assign div_ready = (div_start && (div_cnt == div_lat - 1)) || stray_ready;
    assign div_result = div_start ? ref_div(div_opdata1, div_opdata2, div_signed)
                                  : 64'hdead_beef_cafe_f00d;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
        int          starts;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_expect(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int lat);
        exp_t e;
        logic [63:0] r;
        e.stall  = 0;
        e.starts = 0;
        case (o)
            3'd0, 3'd1: begin
                r = ref_mul(a, b, !o[0]);
                hi_m = r[63:32];
                lo_m = r[31:0];
                e.stall = MUL_LAT + 1;
            end
            3'd2, 3'd3: begin
                if (b != 32'd0) begin
                    r = ref_div(a, b, !o[0]);
                    hi_m = r[63:32];
                    lo_m = r[31:0];
                    e.stall  = lat;
                    e.starts = lat;
                end
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
        e.hi = hi_m;
        e.lo = lo_m;
        exp_q.push_back(e);
    endtask

    // Monitor: counts stall/start cycles of the EX instruction and checks HI/LO
    // the cycle after the instruction leaves EX.
    initial begin
        int   stall_seen = 0;
        int   start_seen = 0;
        int   adv_stall  = 0;
        int   adv_start  = 0;
        logic pending    = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo_o}, {32'd0, e.lo});
                    chk("stall_cycles", 64'(adv_stall), 64'(e.stall));
                    chk("div_start_cycles", 64'(adv_start), 64'(e.starts));
                end
            end
            if (rst || flush) begin
                stall_seen = 0;
                start_seen = 0;
            end else if (op_valid) begin
                if (stallreq) stall_seen++;
                if (div_start) start_seen++;
                if (ex_advance && !stallreq) begin
                    adv_stall  = stall_seen;
                    adv_start  = start_seen;
                    stall_seen = 0;
                    start_seen = 0;
                    pending    = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge; returns #1 after the edge that ends the
    // cycle in which the instruction advanced.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int lat);
        int   guard = 0;
        logic adv;
        div_lat = lat;
        push_expect(o, a, b, lat);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        forever begin
            #1;
            adv = !stallreq && (hold == 0);
            if (!stallreq && hold > 0) hold--;
            ex_advance = adv;
            @(posedge clk);
            #1;
            if (adv) break;
            guard++;
            if (guard > 300) begin
                checks++;
                errors++;
                $display("FAIL timeout: op %0d still in EX after %0d cycles", o, guard);
                break;
            end
        end
        op_valid   = 1'b0;
        ex_advance = 1'b0;
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            ex_advance = 1'($urandom);
            @(posedge clk);
            #1;
        end
        ex_advance = 1'b0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          wait_cnt;
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        ex_advance = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stallreq", {63'd0, stallreq}, 64'd0);
        chk("rst_div_start", {63'd0, div_start}, 64'd0);
        chk("rst_mul_ops", {mul_ina, mul_inb}, 64'd0);
        chk("rst_div_ops", {div_opdata1, div_opdata2}, 64'd0);
        chk("rst_signs_annul", {61'd0, mul_signed, div_signed, div_annul}, 64'd0);

        // Directed cases
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 33);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 33);
        issue(3'd3, 32'd100, 32'd7, 0, 33);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 33);
        issue(3'd4, 32'd5, 32'd0, 0, 33);
        issue(3'd5, 32'd6, 32'd0, 0, 33);
        issue(3'd2, 32'd123, 32'd0, 0, 33);
        issue(3'd4, 32'h1234_5678, 32'd0, 0, 33);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0, 0, 33);
        issue(3'd0, 32'h0000_1234, 32'h0000_5678, 4, 33);
        issue(3'd3, 32'hFFFF_0000, 32'd13, 3, 5);
        idle(2);

        // Randomized mix
        for (int n = 0; n < 150; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) rb = -rb;
            issue(ro, ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                  $urandom_range(1, 40));
            idle($urandom_range(0, 2));
        end
        idle(2);

        // Flush ten cycles into a divide
        div_lat  = 1000;
        op_valid = 1'b1; op = 3'd3; src_a = $urandom; src_b = 32'd9; ex_advance = 1'b0;
        @(posedge clk); #1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        chk("flush_stallreq", {63'd0, stallreq}, 64'd0);
        chk("flush_annul", {63'd0, div_annul}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0;
        chk("post_flush_annul", {63'd0, div_annul}, 64'd0);
        chk("post_flush_busy", {63'd0, busy}, 64'd0);
        chk("post_flush_div_start", {63'd0, div_start}, 64'd0);
        chk("post_flush_hilo", {hi_o, lo_o}, {hi_m, lo_m});
        idle(3);
        stray_ready = 1'b1;
        @(posedge clk); #1;
        stray_ready = 1'b0;
        @(posedge clk); #1;
        chk("stray_ready_hilo", {hi_o, lo_o}, {hi_m, lo_m});
        chk("stray_ready_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a multiply
        op_valid = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd9;
        @(posedge clk); #1;
        rst = 1'b1; op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("midop_rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("midop_rst_busy", {63'd0, busy}, 64'd0);
        issue(3'd4, 32'hA5A5_5A5A, 32'd0, 0, 33);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the EX stage. Issues MULT/MULTU to the fixed-latency multiplier and DIV/DIVU to the iterative divider (start/ready handshake), and raises a stall request while either is busy. Commits the 64-bit results to HI/LO and executes MTHI/MTLO. Sits beside the EX ALU. Its stall request feeds the pipeline stall controller, and hi_o/lo_o feed MFHI/MFLO.

## Interface
- MUL_LAT, 2, multiplier latency in cycles (legal 1..7): mul_result is valid MUL_LAT cycles after stable inputs.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  the instruction in EX is a HI/LO-class op
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 are no-ops
- src_a  in  32  rs value (dividend / multiplicand / MT source)
- src_b  in  32  rt value (divisor / multiplier)
- ex_advance  in  1  the EX instruction moves to MEM at the end of this cycle
- flush  in  1  abort the in-flight operation
- stallreq  out  1  hold EX (combinational)
- busy  out  1  state is not IDLE
- hi_o, lo_o  out  32 each  architectural HI/LO (registered)
- mul_signed  out  1  multiplier sign mode
- mul_ina, mul_inb  out  32 each  multiplier operands
- mul_result  in  64  {hi, lo} product
- div_start  out  1  divider start, level, held until ready
- div_signed  out  1  divider sign mode
- div_opdata1, div_opdata2  out  32 each  dividend, divisor
- div_annul  out  1  one-cycle divider abort
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid (one-cycle pulse)

## Operation
- FSM states: IDLE, MUL, DIV, WAIT_ADV.
- Operand latches: opa, opb, sgn, and a 3-bit count cnt.
- **IDLE**, op_valid with op 0/1 (multiply):
  - Latch opa=src_a, opb=src_b, sgn=~op[0], cnt=MUL_LAT-1.
  - Go to MUL. stallreq=1 this cycle.
- **IDLE**, op_valid with op 2/3 and src_b≠0 (divide): latch the same operands, go to DIV, stallreq=1.
- **IDLE**, op_valid with op 2/3 and src_b==0: divide by zero is skipped.
  - HI/LO unchanged, stallreq=0.
  - Next state WAIT_ADV, or IDLE if ex_advance.
- **IDLE**, op 4/5: HI (op 4) or LO (op 5) takes src_a at the clock edge. stallreq=0. Next state as for divide by zero.
- **IDLE**, op 6/7 or op_valid=0: no action.
- **MUL**:
  - mul_ina=opa, mul_inb=opb, mul_signed=sgn. stallreq=1.
  - cnt decrements each cycle.
  - When cnt==0: {HI,LO}←mul_result, go to WAIT_ADV.
- **DIV**:
  - div_start=1, operands from the latches, div_signed=sgn.
  - stallreq=~div_ready.
  - On div_ready: HI←div_result[63:32], LO←div_result[31:0]. Next state IDLE if ex_advance, else WAIT_ADV.
- **WAIT_ADV**:
  - stallreq=0. op_valid is ignored, which prevents re-execution while downstream stalls hold EX.
  - Go to IDLE on ex_advance.
- Outside MUL/DIV, the multiplier/divider outputs are 0 and div_start=0.
- **flush** has highest priority in every state:
  - Next state IDLE, with no HI/LO write that cycle.
  - div_annul=1 for that cycle if the state is DIV; stallreq=0.
- busy = (state≠IDLE).

## Timing
- Reset values: state IDLE, hi_o=lo_o=0, latches 0, all outputs 0. Reset mid-operation abandons it; HI/LO are forced to 0.
- Multiply issued in cycle T:
  - stallreq=1 in cycles T..T+MUL_LAT.
  - mul_result is sampled at the end of T+MUL_LAT; HI/LO show the product in T+MUL_LAT+1.
  - stallreq=0 from T+MUL_LAT+1.
- Divide issued in cycle T: div_start=1 from T+1 until the ready cycle R inclusive. stallreq=0 in R; HI/LO are updated at R+1.
- MTHI/MTLO: zero stall; the value is visible on hi_o/lo_o in the next cycle.
- div_ready outside DIV is ignored.
- op_valid in MUL or DIV is the held, stalled instruction and is ignored.

## Test plan
- **Signed multiply** (MUL_LAT=2): MULT src_a=0xFFFFFFFE (-2), src_b=3.
  - Required: stallreq high for 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **Divide**: DIVU src_a=100, src_b=7, with the divider model asserting ready 33 cycles after start.
  - Required: div_start held for 33 cycles, stallreq low in the ready cycle, then HI=2, LO=14.
  - DIV src_a=-7, src_b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- **Divide by zero**: DIV src_b=0 with HI=5, LO=6 beforehand.
  - Required: no div_start, stallreq never high, HI=5 and LO=6 unchanged.
- **MTHI/MTLO back to back**: MTHI 0x12345678 then MTLO 0x9ABCDEF0, ex_advance=1 each cycle.
  - Required: hi_o/lo_o update one cycle after each issue, zero stall.
- **Downstream hold**: MULT completes, then ex_advance=0 for 4 cycles with op_valid still high.
  - Required: HI/LO written exactly once, state in WAIT_ADV, no second multiply.
- **Flush mid-divide**: flush 10 cycles into DIV.
  - Required: div_annul pulses once, state returns to IDLE, HI/LO unchanged, stallreq drops in the flush cycle.
  - A later div_ready pulse has no effect.
